// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch constants and the fetch-buffer entry type
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [DATA_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-2 register FIFO with flush taking priority over push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A pop frees the slot, so a full FIFO may still accept a push that cycle.
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch buffer between Instruction_Memory and decode
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_instruction,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instruction,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_pc_plus4,
  output logic [$clog2(FIFO_DEPTH):0]   buf_count
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * WORD_BYTES);
  localparam logic [31:0] STEP       = 32'(WORD_BYTES);

  logic [31:0]  pc;
  logic [31:0]  target_aligned;
  logic         full;
  logic         empty;
  logic         enq;
  logic         deq;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign target_aligned = redirect_target & ~32'h3;
  assign deq            = !empty && out_ready && !redirect;
  assign enq            = !redirect && (!full || deq);
  assign imem_addr      = pc;

  // Out-of-range fetches become NOPs so undriven memory never reaches decode.
  always_comb begin
    wr_entry.pc    = pc;
    wr_entry.instr = (pc < IMEM_BYTES) ? imem_instruction : NOP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= target_aligned;
    else if (enq)      pc <= pc + STEP;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (buf_count)
  );

  assign out_valid       = !empty;
  assign out_pc          = empty ? 32'h0 : head.pc;
  assign out_instruction = empty ? NOP   : head.instr;
  assign out_pc_plus4    = empty ? 32'h0 : head.pc + STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit with an imem model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  buf_count;

  logic [31:0] imem [64];
  logic [31:0] sb_pc [$];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Out-of-range reads return junk; the unit must replace it with NOP.
  assign imem_instruction = (imem_addr < 32'd256) ? imem[imem_addr[7:2]] : 32'hDEADBEEF;

  instr_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .out_pc_plus4     (out_pc_plus4),
    .buf_count        (buf_count)
  );

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    return (p < 32'd256) ? imem[p[7:2]] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    sb_pc.delete();
    for (int i = 0; i < n; i++) sb_pc.push_back(start + 32'(4 * i));
  endtask

  // Compare any handshake that the coming edge will complete, then advance one cycle.
  task automatic tick();
    logic [31:0] p;
    if (out_valid && out_ready && !redirect) begin
      total++;
      assert (sb_pc.size() > 0) passed++;
      else $error("FAIL sb_underflow: observed pc %h expected no delivery", out_pc);
      if (sb_pc.size() > 0) begin
        p = sb_pc.pop_front();
        chk("sb_pc", out_pc, p);
        chk("sb_instr", out_instruction, exp_instr(p));
        chk("sb_pc_plus4", out_pc_plus4, p + 32'd4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = 32'h8C010000;
    imem[1]  = 32'h8C020004;
    imem[10] = 32'h00221820;
    imem[63] = 32'h12345678;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_target = 32'h0;
    out_ready = 1'b0;

    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_count", {29'h0, buf_count}, 32'h0);

    // Streaming with decode always ready
    do_reset();
    out_ready = 1'b1;
    push_seq(32'h0, 64);
    tick();
    chk("first_valid", {31'h0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("stream_count", {29'h0, buf_count}, 32'h1);

    // Stall fills the buffer and freezes the PC
    do_reset();
    out_ready = 1'b0;
    push_seq(32'h0, 64);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_count", {29'h0, buf_count}, 32'h4);
    chk("stall_imem_addr", imem_addr, 32'h10);
    out_ready = 1'b1;
    tick();
    chk("full_deq_count", {29'h0, buf_count}, 32'h4);
    for (int i = 0; i < 6; i++) tick();

    // Redirect with 3 entries buffered
    do_reset();
    out_ready = 1'b0;
    push_seq(32'h0, 64);
    for (int i = 0; i < 3; i++) tick();
    chk("pre_redir_count", {29'h0, buf_count}, 32'h3);
    redirect = 1'b1;
    redirect_target = 32'h28;
    push_seq(32'h28, 64);
    tick();
    redirect = 1'b0;
    chk("redir_count", {29'h0, buf_count}, 32'h0);
    chk("redir_imem_addr", imem_addr, 32'h28);
    chk("redir_valid_n1", {31'h0, out_valid}, 32'h0);
    tick();
    chk("redir_valid_n2", {31'h0, out_valid}, 32'h1);
    chk("redir_pc_n2", out_pc, 32'h28);
    chk("redir_instr_n2", out_instruction, 32'h00221820);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Redirect coinciding with a handshake, unaligned target
    chk("coinc_valid", {31'h0, out_valid}, 32'h1);
    redirect = 1'b1;
    redirect_target = 32'h2B;
    push_seq(32'h28, 64);
    tick();
    redirect = 1'b0;
    chk("mask_imem_addr", imem_addr, 32'h28);
    chk("coinc_count", {29'h0, buf_count}, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back redirects, last wins, then run past the end of memory
    redirect = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_target = 32'h80;
    tick();
    chk("b2b_count", {29'h0, buf_count}, 32'h0);
    chk("b2b_valid", {31'h0, out_valid}, 32'h0);
    redirect_target = 32'hFC;
    tick();
    redirect = 1'b0;
    chk("b2b_imem_addr", imem_addr, 32'hFC);
    push_seq(32'hFC, 16);
    for (int i = 0; i < 5; i++) tick();

    // PC wraps modulo 2^32
    redirect = 1'b1;
    redirect_target = 32'hFFFFFFF8;
    push_seq(32'hFFFFFFF8, 16);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("prefull_count", {29'h0, buf_count}, 32'h4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", {29'h0, buf_count}, 32'h0);
    chk("async_valid", {31'h0, out_valid}, 32'h0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_instr", out_instruction, 32'h0);
    chk("async_pc_plus4", out_pc_plus4, 32'h0);
    chk("async_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    push_seq(32'h0, 8);
    tick();
    chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("post_rst_pc", out_pc, 32'h0);
    chk("post_rst_imem_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
